// File: rtl/pipeline_ctrl.sv
// Fetch-side pipeline control: PC redirects, trap insertion and serialising drains.
// All outputs are Mealy; the state, latched trap PC and drain counter are registered.
module pipeline_ctrl #(
   parameter int XLEN        = 32,
   parameter int NSTAGES     = 2,
   parameter int CNT_W       = 8,
   parameter int DRAIN_LIMIT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               jump,
   input  logic [XLEN-1:0]    jump_pc,
   input  logic               trap_req,
   input  logic [XLEN-1:0]    trap_pc,
   input  logic               serial_req,
   input  logic [NSTAGES-1:0] stage_empty,
   output logic               next_pc_en,
   output logic [XLEN-1:0]    next_pc,
   output logic               bubble_fetch,
   output logic               trap_insert,
   output logic               trap_pending,
   output logic               serial_pending,
   output logic [CNT_W-1:0]   drain_cnt,
   output logic               drain_err
);

   typedef enum logic [1:0] {
      RUN          = 2'd0,
      TRAP_DRAIN   = 2'd1,
      SERIAL_DRAIN = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(DRAIN_LIMIT);

   state_t            state_q, state_d;
   logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              all_empty;
   logic              en_c;
   logic [XLEN-1:0]   pc_c;
   logic              bubble_c;
   logic              insert_c;

   assign all_empty = &stage_empty;

   always_comb begin
      state_d   = state_q;
      trap_pc_d = trap_pc_q;
      en_c      = 1'b0;
      pc_c      = jump_pc;
      bubble_c  = 1'b0;
      insert_c  = 1'b0;
      case (state_q)
         RUN: begin
            if (trap_req) begin
               if (all_empty && !jump) begin
                  insert_c = 1'b1;
                  en_c     = 1'b1;
                  pc_c     = trap_pc;
               end else begin
                  trap_pc_d = trap_pc;
                  state_d   = TRAP_DRAIN;
                  bubble_c  = 1'b1;
               end
            end else if (serial_req) begin
               state_d  = SERIAL_DRAIN;
               bubble_c = 1'b1;
            end
         end
         TRAP_DRAIN: begin
            // Later trap requests are dropped: the first trap owns the drain.
            bubble_c = 1'b1;
            if (all_empty && !jump) begin
               insert_c = 1'b1;
               en_c     = 1'b1;
               pc_c     = trap_pc_q;
               state_d  = RUN;
            end
         end
         SERIAL_DRAIN: begin
            if (trap_req) begin
               trap_pc_d = trap_pc;
               state_d   = TRAP_DRAIN;
               bubble_c  = 1'b1;
            end else begin
               bubble_c = !all_empty;
               if (all_empty) begin
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
      // A jump always wins the fetch mux and blocks any insert this cycle.
      if (jump) begin
         en_c     = 1'b1;
         pc_c     = jump_pc;
         bubble_c = 1'b1;
         insert_c = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == RUN || state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
      err_d = err_q | ((state_q != RUN) && (cnt_q == LIMIT_C));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         trap_pc_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         trap_pc_q <= trap_pc_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign next_pc_en     = !rst && en_c;
   assign next_pc        = rst ? jump_pc : pc_c;
   assign bubble_fetch   = rst || bubble_c;
   assign trap_insert    = !rst && insert_c;
   assign trap_pending   = !rst && (state_q == TRAP_DRAIN);
   assign serial_pending = !rst && (state_q == SERIAL_DRAIN);
   assign drain_cnt      = rst ? '0 : cnt_q;
   assign drain_err      = !rst && err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (NSTAGES=2, CNT_W=8, DRAIN_LIMIT=4).
// Each scenario is a table of per-cycle inputs and expected Mealy outputs.
module tb_pipeline_ctrl;

   typedef struct packed {
      logic        en;
      logic [31:0] pc;
      logic        bub;
      logic        ins;
      logic        tp;
      logic        sp;
      logic [7:0]  cnt;
      logic        err;
   } out_t;

   typedef struct packed {
      logic        rst;
      logic        jump;
      logic [31:0] jpc;
      logic        treq;
      logic [31:0] tpc;
      logic        sreq;
      logic [1:0]  se;
      out_t        exp;
   } step_t;

   logic        clk;
   logic        rst;
   logic        jump;
   logic [31:0] jump_pc;
   logic        trap_req;
   logic [31:0] trap_pc;
   logic        serial_req;
   logic [1:0]  stage_empty;
   logic        next_pc_en;
   logic [31:0] next_pc;
   logic        bubble_fetch;
   logic        trap_insert;
   logic        trap_pending;
   logic        serial_pending;
   logic [7:0]  drain_cnt;
   logic        drain_err;

   out_t exp_q[$];
   int   n_vec;
   int   n_err;

   pipeline_ctrl #(
      .XLEN(32), .NSTAGES(2), .CNT_W(8), .DRAIN_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst), .jump(jump), .jump_pc(jump_pc),
      .trap_req(trap_req), .trap_pc(trap_pc), .serial_req(serial_req),
      .stage_empty(stage_empty), .next_pc_en(next_pc_en), .next_pc(next_pc),
      .bubble_fetch(bubble_fetch), .trap_insert(trap_insert),
      .trap_pending(trap_pending), .serial_pending(serial_pending),
      .drain_cnt(drain_cnt), .drain_err(drain_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic step_t mk(input logic r, input logic j, input logic [31:0] jpc,
                                input logic tr, input logic [31:0] tpc, input logic sr,
                                input logic [1:0] se, input logic en, input logic [31:0] pc,
                                input logic bub, input logic ins, input logic tp,
                                input logic sp, input logic [7:0] cnt, input logic err);
      step_t s;
      s.rst = r; s.jump = j; s.jpc = jpc; s.treq = tr; s.tpc = tpc; s.sreq = sr; s.se = se;
      s.exp = '{en: en, pc: pc, bub: bub, ins: ins, tp: tp, sp: sp, cnt: cnt, err: err};
      return s;
   endfunction

   // driver
   task automatic drive(input step_t s);
      rst         = s.rst;
      jump        = s.jump;
      jump_pc     = s.jpc;
      trap_req    = s.treq;
      trap_pc     = s.tpc;
      serial_req  = s.sreq;
      stage_empty = s.se;
   endtask

   function automatic out_t observe();
      return '{en: next_pc_en, pc: next_pc, bub: bubble_fetch, ins: trap_insert,
               tp: trap_pending, sp: serial_pending, cnt: drain_cnt, err: drain_err};
   endfunction

   task automatic test_reset();
      step_t st[$];
      logic [31:0] r;
      for (int k = 0; k < 2; k++) begin
         r = $urandom();
         st.push_back(mk(1, 0, r, 1, 32'h100, 0, 2'b00, 0, r, 1, 0, 0, 0, 8'd0, 0));
      end
      r = $urandom();
      st.push_back(mk(1, 1, r, 1, 32'h100, 1, 2'b11, 0, r, 1, 0, 0, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b00, 0, r, 0, 0, 0, 0, 8'd0, 0));
      foreach (st[i]) begin
         out_t got, exp;
         @(negedge clk);
         drive(st[i]);
         exp_q.push_back(st[i].exp);
         #2;
         got = observe();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset[%0d]: got %h expected %h", i, got, exp);
         end
      end
   endtask

   task automatic test_immediate_trap();
      step_t st[$];
      logic [31:0] r1, r2;
      r1 = $urandom(); r2 = $urandom();
      st.push_back(mk(0, 0, r1, 1, 32'h100, 0, 2'b11, 1, 32'h100, 0, 1, 0, 0, 8'd0, 0));
      st.push_back(mk(0, 0, r2, 0, 32'h0, 0, 2'b11, 0, r2, 0, 0, 0, 0, 8'd0, 0));
      foreach (st[i]) begin
         out_t got, exp;
         @(negedge clk);
         drive(st[i]);
         exp_q.push_back(st[i].exp);
         #2;
         got = observe();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL immediate_trap[%0d]: got %h expected %h", i, got, exp);
         end
      end
   endtask

   task automatic test_drained_trap();
      step_t st[$];
      logic [31:0] r;
      r = $urandom();
      st.push_back(mk(0, 0, r, 1, 32'h100, 0, 2'b00, 0, r, 1, 0, 0, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'hDEAD, 0, 2'b00, 0, r, 1, 0, 1, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'hDEAD, 0, 2'b10, 0, r, 1, 0, 1, 0, 8'd1, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 1, 32'hDEAD, 0, 2'b01, 0, r, 1, 0, 1, 0, 8'd2, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'hDEAD, 0, 2'b11, 1, 32'h100, 1, 1, 1, 0, 8'd3, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'hDEAD, 0, 2'b11, 0, r, 0, 0, 0, 0, 8'd0, 0));
      foreach (st[i]) begin
         out_t got, exp;
         @(negedge clk);
         drive(st[i]);
         exp_q.push_back(st[i].exp);
         #2;
         got = observe();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL drained_trap[%0d]: got %h expected %h", i, got, exp);
         end
      end
   endtask

   task automatic test_jump_blocks();
      step_t st[$];
      logic [31:0] r;
      r = $urandom();
      st.push_back(mk(0, 0, r, 1, 32'h180, 0, 2'b01, 0, r, 1, 0, 0, 0, 8'd0, 0));
      st.push_back(mk(0, 1, 32'h200, 0, 32'h0, 0, 2'b11, 1, 32'h200, 1, 0, 1, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 1, 32'h180, 1, 1, 1, 0, 8'd1, 0));
      st.push_back(mk(0, 1, 32'h240, 0, 32'h0, 0, 2'b11, 1, 32'h240, 1, 0, 0, 0, 8'd0, 0));
      // jump beside a trap on an empty pipeline defers the trap into a drain
      st.push_back(mk(0, 1, 32'h280, 1, 32'h2C0, 0, 2'b11, 1, 32'h280, 1, 0, 0, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 1, 32'h2C0, 1, 1, 1, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 0, r, 0, 0, 0, 0, 8'd0, 0));
      foreach (st[i]) begin
         out_t got, exp;
         @(negedge clk);
         drive(st[i]);
         exp_q.push_back(st[i].exp);
         #2;
         got = observe();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL jump_blocks[%0d]: got %h expected %h", i, got, exp);
         end
      end
   endtask

   task automatic test_serial();
      step_t st[$];
      logic [31:0] r;
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 1, 2'b10, 0, r, 1, 0, 0, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b10, 0, r, 1, 0, 0, 1, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 0, r, 0, 0, 0, 1, 8'd1, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b00, 0, r, 0, 0, 0, 0, 8'd0, 0));
      // serial drain superseded by a trap
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 1, 2'b01, 0, r, 1, 0, 0, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 1, 32'h300, 0, 2'b01, 0, r, 1, 0, 0, 1, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b01, 0, r, 1, 0, 1, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 1, 32'h300, 1, 1, 1, 0, 8'd1, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 0, r, 0, 0, 0, 0, 8'd0, 0));
      foreach (st[i]) begin
         out_t got, exp;
         @(negedge clk);
         drive(st[i]);
         exp_q.push_back(st[i].exp);
         #2;
         got = observe();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL serial[%0d]: got %h expected %h", i, got, exp);
         end
      end
   endtask

   task automatic test_drain_limit();
      step_t st[$];
      logic [31:0] r;
      logic [7:0]  c;
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 1, 2'b00, 0, r, 1, 0, 0, 0, 8'd0, 0));
      for (int k = 0; k <= 257; k++) begin
         r = $urandom();
         c = (k > 255) ? 8'd255 : 8'(k);
         st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'(k % 3), 0, r, 1, 0, 0, 1, c, (k >= 5)));
      end
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 0, r, 0, 0, 0, 1, 8'd255, 1));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 0, r, 0, 0, 0, 0, 8'd0, 1));
      r = $urandom();
      st.push_back(mk(1, 0, r, 0, 32'h0, 0, 2'b11, 0, r, 1, 0, 0, 0, 8'd0, 0));
      r = $urandom();
      st.push_back(mk(0, 0, r, 0, 32'h0, 0, 2'b11, 0, r, 0, 0, 0, 0, 8'd0, 0));
      foreach (st[i]) begin
         out_t got, exp;
         @(negedge clk);
         drive(st[i]);
         exp_q.push_back(st[i].exp);
         #2;
         got = observe();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL drain_limit[%0d]: got %h expected %h", i, got, exp);
         end
      end
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst         = 1'b1;
      jump        = 1'b0;
      jump_pc     = '0;
      trap_req    = 1'b0;
      trap_pc     = '0;
      serial_req  = 1'b0;
      stage_empty = 2'b00;
      test_reset();
      test_immediate_trap();
      test_drained_trap();
      test_jump_blocks();
      test_serial();
      test_drain_limit();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
